// File: rtl/idct_stage3.sv
// Inverse of the forward IDCT stage-3 butterfly/rotation as a 3-deep valid/ready pipeline.
// Define IDCT_STAGE3_ROUND_EN to round half up on every right shift; otherwise shifts truncate.
module idct_stage3 #(
  parameter int          FRAC_BITS = 16,
  parameter int unsigned C_COEF    = 17734,
  parameter int unsigned S_COEF    = 42814
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] O0,
  input  logic [31:0] O1,
  input  logic [31:0] O2,
  input  logic [31:0] O3,
  input  logic [31:0] O4,
  input  logic [31:0] O5,
  input  logic [31:0] O6,
  input  logic [31:0] O7,
  output logic        valid,
  input  logic        out_ready,
  output logic [31:0] N0,
  output logic [31:0] N1,
  output logic [31:0] N2,
  output logic [31:0] N3,
  output logic [31:0] N4,
  output logic [31:0] N5,
  output logic [31:0] N6,
  output logic [31:0] N7
);

  localparam int PW = 50;
  localparam int SW = 33;

  localparam logic [17:0] C18 = C_COEF[17:0];
  localparam logic [17:0] S18 = S_COEF[17:0];

`ifdef IDCT_STAGE3_ROUND_EN
  localparam logic [PW-1:0] PROD_RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic [SW-1:0] HALF_RND = {{(SW-1){1'b0}}, 1'b1};
`else
  localparam logic [PW-1:0] PROD_RND = '0;
  localparam logic [SW-1:0] HALF_RND = '0;
`endif

  function automatic logic [PW-1:0] sext_prod(input logic [31:0] x);
    return {{(PW-32){x[31]}}, x};
  endfunction

  function automatic logic [PW-1:0] zext_coef(input logic [17:0] c);
    return {{(PW-18){1'b0}}, c};
  endfunction

  function automatic logic [SW-1:0] sext_sum(input logic [31:0] x);
    return {x[31], x};
  endfunction

  // Halving a 33-bit sum always fits back into 32 bits.
  function automatic logic [31:0] halve(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s + HALF_RND;
    return t[SW-1:1];
  endfunction

  // Requires FRAC_BITS + 32 <= PW.
  function automatic logic [31:0] descale(input logic [PW-1:0] p);
    logic [PW-1:0] t;
    t = p + PROD_RND;
    return t[FRAC_BITS +: 32];
  endfunction

  logic advance;

  logic [PW-1:0] p_c2_d, p_s3_d, p_s2_d, p_c3_d;
  logic [SW-1:0] a01_d, d01_d, a46_d, d46_d, a75_d, d75_d;

  logic          s1_valid;
  logic [PW-1:0] s1_p_c2, s1_p_s3, s1_p_s2, s1_p_c3;
  logic [SW-1:0] s1_a01, s1_d01, s1_a46, s1_d46, s1_a75, s1_d75;

  logic          s2_valid;
  logic [PW-1:0] s2_rot2, s2_rot3;
  logic [SW-1:0] s2_a01, s2_d01, s2_a46, s2_d46, s2_a75, s2_d75;

  // The whole pipeline moves as one; a held output blocks every stage.
  assign advance  = en & (out_ready | ~valid);
  assign in_ready = advance & reset;

  always_comb begin
    p_c2_d = sext_prod(O2) * zext_coef(C18);
    p_s3_d = sext_prod(O3) * zext_coef(S18);
    p_s2_d = sext_prod(O2) * zext_coef(S18);
    p_c3_d = sext_prod(O3) * zext_coef(C18);
    a01_d  = sext_sum(O0) + sext_sum(O1);
    d01_d  = sext_sum(O0) - sext_sum(O1);
    a46_d  = sext_sum(O4) + sext_sum(O6);
    d46_d  = sext_sum(O4) - sext_sum(O6);
    a75_d  = sext_sum(O7) + sext_sum(O5);
    d75_d  = sext_sum(O7) - sext_sum(O5);
  end

  // Intermediate stages carry no reset; their valid bits mark what is meaningful.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_p_c2 <= p_c2_d;
      s1_p_s3 <= p_s3_d;
      s1_p_s2 <= p_s2_d;
      s1_p_c3 <= p_c3_d;
      s1_a01  <= a01_d;
      s1_d01  <= d01_d;
      s1_a46  <= a46_d;
      s1_d46  <= d46_d;
      s1_a75  <= a75_d;
      s1_d75  <= d75_d;

      s2_rot2 <= s1_p_c2 - s1_p_s3;
      s2_rot3 <= s1_p_s2 + s1_p_c3;
      s2_a01  <= s1_a01;
      s2_d01  <= s1_d01;
      s2_a46  <= s1_a46;
      s2_d46  <= s1_d46;
      s2_a75  <= s1_a75;
      s2_d75  <= s1_d75;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      valid    <= 1'b0;
      N0       <= '0;
      N1       <= '0;
      N2       <= '0;
      N3       <= '0;
      N4       <= '0;
      N5       <= '0;
      N6       <= '0;
      N7       <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      valid    <= s2_valid;
      N0       <= halve(s2_a01);
      N1       <= halve(s2_d01);
      N2       <= descale(s2_rot2);
      N3       <= descale(s2_rot3);
      N4       <= halve(s2_a46);
      N5       <= halve(s2_d75);
      N6       <= halve(s2_d46);
      N7       <= halve(s2_a75);
    end
  end

endmodule

// File: doc/idct_stage3.md
IDCT_STAGE3 -- requirements
Module: idct_stage3

Interface
REQ-001 Parameter FRAC_BITS, default 16, fractional bits of the signed Q16.16 sample format.
REQ-002 Parameter C_COEF, default 17734, round(cos(3pi/8)*sqrt(2)/2 * 2^FRAC_BITS), unsigned.
REQ-003 Parameter S_COEF, default 42814, round(sin(3pi/8)*sqrt(2)/2 * 2^FRAC_BITS), unsigned.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 en  input  1  global pipeline enable; low freezes all state.
REQ-007 in_valid  input  1  O0..O7 carry a vector this cycle.
REQ-008 in_ready  output  1  block accepts a vector this cycle.
REQ-009 O0..O7  input  32 each  forward-stage-3 coefficients, signed Q16.16.
REQ-010 valid  output  1  N0..N7 carry a result vector.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 N0..N7  output  32 each  recovered stage-3 inputs, signed Q16.16.

Function
REQ-013 The block inverts the forward stage-3 butterfly/rotation: N0=(O0+O1)/2, N1=(O0-O1)/2, N4=(O4+O6)/2, N6=(O4-O6)/2, N7=(O7+O5)/2, N5=(O7-O5)/2.
REQ-014 Rotation: N2=(C_COEF*O2 - S_COEF*O3)>>>FRAC_BITS, N3=(S_COEF*O2 + C_COEF*O3)>>>FRAC_BITS.
REQ-015 Sums/differences are formed at 33 bits, then arithmetically shifted right by 1 and truncated to 32 bits; no overflow possible.
REQ-016 Products are signed 32x18-bit (coefficient zero-extended), accumulated at 50 bits, shifted by FRAC_BITS, and the low 32 bits kept.
REQ-017 Three-stage pipeline: S1 registers the four products and six butterfly sums; S2 registers the two product sums and forwards the butterfly values; S3 applies the shift/round and drives the output registers.
REQ-018 A transfer occurs on in_valid&in_ready; its result appears with valid high exactly 3 cycles later when no stall occurs.
REQ-019 advance = en & (out_ready | ~valid); in_ready = advance; all stage registers and stage valid bits load only when advance is high.
REQ-020 An empty (bubble) stage is carried as a cleared valid bit; bubbles are not collapsed.
REQ-021 While valid=1 and out_ready=0, N0..N7 and valid hold stable; no input is accepted.
REQ-022 en=0: in_ready=0, all registers hold, valid keeps its value.
REQ-023 Simultaneous output consumption and input acceptance in the same cycle is supported at full throughput (one vector per cycle).
REQ-024 All eight outputs of one vector are presented in the same cycle.

Reset
REQ-025 When reset=0 at a clock edge, all stage valid bits, valid and N0..N7 clear to 0, discarding in-flight vectors.
REQ-026 During reset=0, in_ready=0; the first transfer can occur in the cycle after reset returns high.

Configuration
REQ-027 Macro IDCT_STAGE3_ROUND_EN defined: every right shift (halving and >>>FRAC_BITS) adds 2^(shift-1) before shifting (round half up).
REQ-028 Macro IDCT_STAGE3_ROUND_EN undefined: every right shift truncates toward negative infinity; latency and handshake are identical in both builds.

Verification
REQ-029 O0=0x00020000, O1=0 -> N0=N1=0x00010000; O4=0x00030000, O6=0x00010000 -> N4=0x00020000, N6=0x00010000; O7=0x00050000, O5=0x00010000 -> N7=0x00030000, N5=0x00020000; valid 3 cycles after transfer.
REQ-030 O2=0x00010000, O3=0 -> N2=0x00004546, N3=0x0000A73E; O2=0, O3=0x00010000 -> N2=0xFFFF58C2, N3=0x00004546.
REQ-031 O0=1, O1=0: no ROUND_EN -> N0=0, N1=0; with ROUND_EN -> N0=1, N1=1.
REQ-032 Stream 8 vectors back-to-back with out_ready=1 -> 8 results on 8 consecutive cycles, in order; then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, no vector lost or duplicated.
REQ-033 Reset asserted with 2 vectors in flight -> valid=0, N0..N7=0 next cycle; no stale result emerges after reset release.
REQ-034 en=0 for 3 cycles mid-stream -> in_ready=0, all outputs frozen; results resume in order when en returns to 1.
